// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the execute stage and its ALU.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [1:0] AOK = 2'b00;
  localparam logic [1:0] HLT = 2'b01;
  localparam logic [1:0] ADR = 2'b10;
  localparam logic [1:0] INS = 2'b11;

  localparam logic [3:0] RNONE = 4'hF;

  function automatic logic cond_true(input logic [3:0] fn, input logic [2:0] flags);
    logic zf, sf, of;
    {zf, sf, of} = flags;
    case (fn)
      C_YES:   cond_true = 1'b1;
      C_LE:    cond_true = (sf ^ of) | zf;
      C_L:     cond_true = sf ^ of;
      C_E:     cond_true = zf;
      C_NE:    cond_true = ~zf;
      C_GE:    cond_true = ~(sf ^ of);
      C_G:     cond_true = ~(sf ^ of) & ~zf;
      default: cond_true = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU: result = b <fun> a, with zero/sign/overflow flags.
module y86_alu
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   fun,
  output logic [W-1:0] result,
  output logic         zf,
  output logic         sf,
  output logic         of
);

  always_comb begin
    result = '0;
    of     = 1'b0;
    case (fun)
      ALU_ADD: begin
        result = b + a;
        of     = (a[W-1] == b[W-1]) & (result[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        result = b - a;
        of     = (a[W-1] != b[W-1]) & (result[W-1] != b[W-1]);
      end
      ALU_AND: result = b & a;
      ALU_XOR: result = b ^ a;
      default: result = '0;
    endcase
    zf = (result == '0);
    sf = result[W-1];
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, cmov/jXX condition, registered E/M slot.
module execute_stage
  import y86_pkg::*;
#(
  parameter int         W          = 64,
  parameter int         STACK_STEP = 8,
  parameter logic [3:0] RNONE      = 4'hF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  input  logic [W-1:0] valP,
  input  logic [3:0]   dstE_in,
  input  logic [3:0]   dstM_in,
  input  logic [1:0]   stat_in,
  input  logic         instr_valid,
  input  logic         imem_error,
  input  logic         down_exc,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   m_icode,
  output logic [W-1:0] m_valE,
  output logic [W-1:0] m_valA,
  output logic [W-1:0] m_valP,
  output logic [3:0]   m_dstE,
  output logic [3:0]   m_dstM,
  output logic         m_cnd,
  output logic [1:0]   m_stat,
  output logic [2:0]   cc
);

  localparam logic [W-1:0] STEP = W'(STACK_STEP);

  logic [W-1:0] alu_res;
  logic         alu_zf, alu_sf, alu_of;
  logic         xfer, bad_fun, cnd, cc_we;
  logic [1:0]   stat;
  logic [W-1:0] val_e;
  logic [3:0]   dst_e;

  y86_alu #(.W(W)) u_alu (
    .a      (valA),
    .b      (valB),
    .fun    (ifun),
    .result (alu_res),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  assign in_ready = ~out_valid | out_ready;
  assign xfer     = in_valid & in_ready;

  assign bad_fun = ((icode == IOPQ) && (ifun > ALU_XOR)) ||
                   (((icode == IRRMOVQ) || (icode == IJXX)) && (ifun > C_G));

  always_comb begin
    if (imem_error)                 stat = ADR;
    else if (!instr_valid || bad_fun) stat = INS;
    else if (stat_in != AOK)        stat = stat_in;
    else if (icode == IHALT)        stat = HLT;
    else                            stat = AOK;
  end

  // Condition reads cc as held before this cycle's possible OPq update
  assign cnd = ((icode == IRRMOVQ) || (icode == IJXX)) ? cond_true(ifun, cc) : 1'b0;

  always_comb begin
    case (icode)
      IRRMOVQ:          val_e = valA;
      IIRMOVQ:          val_e = valC;
      IRMMOVQ, IMRMOVQ: val_e = valB + valC;
      IOPQ:             val_e = alu_res;
      ICALL, IPUSHQ:    val_e = valB - STEP;
      IRET, IPOPQ:      val_e = valB + STEP;
      default:          val_e = '0;
    endcase
  end

  assign dst_e = ((icode == IRRMOVQ) && !cnd) ? RNONE : dstE_in;
  assign cc_we = xfer & (icode == IOPQ) & (stat == AOK) & ~down_exc & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cc <= 3'b100;
    else if (cc_we) cc <= {alu_zf, alu_sf, alu_of};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      m_icode   <= INOP;
      m_valE    <= '0;
      m_valA    <= '0;
      m_valP    <= '0;
      m_dstE    <= RNONE;
      m_dstM    <= RNONE;
      m_cnd     <= 1'b0;
      m_stat    <= AOK;
    end else if (flush) begin
      out_valid <= 1'b0;
      m_icode   <= INOP;
      m_valE    <= '0;
      m_valA    <= '0;
      m_valP    <= '0;
      m_dstE    <= RNONE;
      m_dstM    <= RNONE;
      m_cnd     <= 1'b0;
      m_stat    <= AOK;
    end else if (xfer) begin
      out_valid <= 1'b1;
      m_icode   <= icode;
      m_valE    <= val_e;
      m_valA    <= valA;
      m_valP    <= valP;
      m_dstE    <= dst_e;
      m_dstM    <= dstM_in;
      m_cnd     <= cnd;
      m_stat    <= stat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed and randomized checks of execute_stage against a behavioural model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  icode, ifun;
  logic [63:0] valA, valB, valC, valP;
  logic [3:0]  dstE_in, dstM_in;
  logic [1:0]  stat_in;
  logic        instr_valid, imem_error, down_exc, flush;
  logic        out_valid, out_ready;
  logic [3:0]  m_icode;
  logic [63:0] m_valE, m_valA, m_valP;
  logic [3:0]  m_dstE, m_dstM;
  logic        m_cnd;
  logic [1:0]  m_stat;
  logic [2:0]  cc;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state
  logic        e_valid;
  logic [3:0]  e_icode, e_dstE, e_dstM;
  logic [63:0] e_valE, e_valA, e_valP;
  logic        e_cnd;
  logic [1:0]  e_stat;
  logic [2:0]  e_cc;

  execute_stage #(.W(64), .STACK_STEP(8), .RNONE(4'hF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC), .valP(valP),
    .dstE_in(dstE_in), .dstM_in(dstM_in), .stat_in(stat_in),
    .instr_valid(instr_valid), .imem_error(imem_error), .down_exc(down_exc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .m_icode(m_icode), .m_valE(m_valE), .m_valA(m_valA), .m_valP(m_valP),
    .m_dstE(m_dstE), .m_dstM(m_dstM), .m_cnd(m_cnd), .m_stat(m_stat), .cc(cc)
  );

  always #5 clk = ~clk;

  function automatic logic ref_cond(input logic [3:0] f, input logic [2:0] c);
    logic less;
    less = c[1] != c[0];
    case (f)
      0: return 1'b1;
      1: return less || c[2];
      2: return less;
      3: return c[2];
      4: return !c[2];
      5: return !less;
      6: return !less && !c[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] ref_stat();
    if (imem_error) return 2'b10;
    if (!instr_valid) return 2'b11;
    if (icode == 6 && ifun > 3) return 2'b11;
    if ((icode == 2 || icode == 7) && ifun > 6) return 2'b11;
    if (stat_in != 2'b00) return stat_in;
    if (icode == 0) return 2'b01;
    return 2'b00;
  endfunction

  // Flags derived from 65-bit sign-extended arithmetic rather than bit tests
  task automatic ref_op(output logic [63:0] r, output logic [2:0] f);
    logic [64:0] wide;
    logic        ovf;
    ovf = 1'b0;
    case (ifun)
      0: begin wide = {valB[63], valB} + {valA[63], valA}; r = wide[63:0]; ovf = wide[64] != wide[63]; end
      1: begin wide = {valB[63], valB} - {valA[63], valA}; r = wide[63:0]; ovf = wide[64] != wide[63]; end
      2: r = valB & valA;
      3: r = valB ^ valA;
      default: r = 64'd0;
    endcase
    f = {r == 64'd0, r[63], ovf};
  endtask

  task automatic model_reset();
    e_valid = 0; e_icode = 4'h1; e_valE = 0; e_valA = 0; e_valP = 0;
    e_dstE = 4'hF; e_dstM = 4'hF; e_cnd = 0; e_stat = 2'b00; e_cc = 3'b100;
  endtask

  task automatic idle_inputs();
    in_valid = 0; icode = 4'h1; ifun = 0; valA = 0; valB = 0; valC = 0; valP = 0;
    dstE_in = 4'hF; dstM_in = 4'hF; stat_in = 0; instr_valid = 1; imem_error = 0;
    down_exc = 0; flush = 0; out_ready = 1;
  endtask

  // Advance one clock; the model steps from the inputs present before the edge
  task automatic tick();
    logic        take, c;
    logic [63:0] ve, opr;
    logic [2:0]  opf;
    logic [1:0]  st;
    take = in_valid && (!e_valid || out_ready);
    st = ref_stat();
    c = (icode == 2 || icode == 7) ? ref_cond(ifun, e_cc) : 1'b0;
    ref_op(opr, opf);
    case (icode)
      2: ve = valA;
      3: ve = valC;
      4, 5: ve = valB + valC;
      6: ve = opr;
      8, 10: ve = valB - 64'd8;
      9, 11: ve = valB + 64'd8;
      default: ve = 64'd0;
    endcase
    @(posedge clk);
    #1;
    if (flush) begin
      e_valid = 0; e_icode = 4'h1; e_valE = 0; e_valA = 0; e_valP = 0;
      e_dstE = 4'hF; e_dstM = 4'hF; e_cnd = 0; e_stat = 2'b00;
    end else if (take) begin
      e_valid = 1; e_icode = icode; e_valE = ve; e_valA = valA; e_valP = valP;
      e_dstE = (icode == 2 && !c) ? 4'hF : dstE_in; e_dstM = dstM_in;
      e_cnd = c; e_stat = st;
      if (icode == 6 && st == 2'b00 && !down_exc) e_cc = opf;
    end else if (out_ready) begin
      e_valid = 0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    #12;
    n_cmp++;
    if ({out_valid, m_icode, m_valE, m_valA, m_valP, m_dstE, m_dstM, m_cnd, m_stat, cc} !==
        {1'b0, 4'h1, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 2'b00, 3'b100}) begin
      n_bad++; $display("FAIL reset_values: got ov=%b ic=%h dstE=%h dstM=%h stat=%b cc=%b", out_valid, m_icode, m_dstE, m_dstM, m_stat, cc);
    end
    @(negedge clk); rst = 1; model_reset();
    // Load a valid slot and change cc, then assert reset between edges
    in_valid = 1; icode = 6; ifun = 0; valA = 1; valB = 2; out_ready = 0;
    tick();
    idle_inputs(); out_ready = 0;
    n_cmp++;
    if (out_valid !== 1'b1 || cc !== 3'b000) begin
      n_bad++; $display("FAIL reset_preload: got ov=%b cc=%b want ov=1 cc=000", out_valid, cc);
    end
    #2 rst = 0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || cc !== 3'b100) begin
      n_bad++; $display("FAIL reset_async: got ov=%b cc=%b want ov=0 cc=100", out_valid, cc);
    end
    @(negedge clk); rst = 1; model_reset(); idle_inputs();
  endtask

  task automatic test_overflow();
    in_valid = 1; icode = 6; ifun = 0; valA = 64'h7FFF_FFFF_FFFF_FFFF; valB = 64'h7FFF_FFFF_FFFF_FFFF; dstE_in = 4'h2;
    tick();
    n_cmp++;
    if (m_valE !== 64'hFFFF_FFFF_FFFF_FFFE || cc !== 3'b011) begin
      n_bad++; $display("FAIL overflow_add: got valE=%h cc=%b want valE=fffffffffffffffe cc=011", m_valE, cc);
    end
    icode = 7; ifun = 2; dstE_in = 4'hF;
    tick();
    n_cmp++;
    if (m_cnd !== 1'b0 || m_icode !== 4'h7) begin
      n_bad++; $display("FAIL jl_after_overflow: got cnd=%b ic=%h want cnd=0 ic=7", m_cnd, m_icode);
    end
    idle_inputs();
  endtask

  task automatic test_sub_zero();
    in_valid = 1; icode = 6; ifun = 1; valA = 5; valB = 5; dstE_in = 4'h1;
    tick();
    n_cmp++;
    if (m_valE !== 64'd0 || cc !== 3'b100) begin
      n_bad++; $display("FAIL sub_zero: got valE=%h cc=%b want valE=0 cc=100", m_valE, cc);
    end
    icode = 2; ifun = 4; valA = 64'd77; dstE_in = 4'd3;
    tick();
    n_cmp++;
    if (m_dstE !== 4'hF || m_cnd !== 1'b0 || m_valE !== 64'd77) begin
      n_bad++; $display("FAIL cmovne_cancel: got dstE=%h cnd=%b valE=%0d want dstE=f cnd=0 valE=77", m_dstE, m_cnd, m_valE);
    end
    icode = 2; ifun = 3; dstE_in = 4'd3;
    tick();
    n_cmp++;
    if (m_dstE !== 4'd3 || m_cnd !== 1'b1) begin
      n_bad++; $display("FAIL cmove_taken: got dstE=%h cnd=%b want dstE=3 cnd=1", m_dstE, m_cnd);
    end
    idle_inputs();
  endtask

  task automatic test_stack_backpressure();
    in_valid = 1; icode = 4'hA; valB = 64'd100; valA = 64'd7; dstE_in = 4'h4;
    tick();
    n_cmp++;
    if (m_valE !== 64'd92 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL push_valE: got valE=%0d ov=%b want valE=92 ov=1", m_valE, out_valid);
    end
    icode = 4'hB; valB = 64'd500; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++; $display("FAIL stall_ready: cycle %0d got in_ready=%b want 0", i, in_ready);
      end
      tick();
      n_cmp++;
      if (m_valE !== 64'd92 || m_icode !== 4'hA || out_valid !== 1'b1) begin
        n_bad++; $display("FAIL stall_hold: cycle %0d got valE=%0d ic=%h ov=%b want 92 a 1", i, m_valE, m_icode, out_valid);
      end
    end
    in_valid = 0; out_ready = 1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL drain_ready: got in_ready=%b want 1", in_ready);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL drain: got ov=%b want 0", out_valid);
    end
    in_valid = 1; icode = 4'h9; valB = 64'd40;
    tick();
    n_cmp++;
    if (m_valE !== 64'd48) begin
      n_bad++; $display("FAIL ret_valE: got %0d want 48", m_valE);
    end
    idle_inputs();
  endtask

  task automatic test_exceptions();
    logic [2:0] cc0;
    in_valid = 1; icode = 6; ifun = 1; valA = 9; valB = 3;
    tick();
    cc0 = e_cc;
    n_cmp++;
    if (cc !== 3'b010) begin
      n_bad++; $display("FAIL sub_neg: got cc=%b want 010", cc);
    end
    icode = 6; ifun = 0; valA = 0; valB = 0; imem_error = 1;
    tick();
    n_cmp++;
    if (m_stat !== 2'b10 || cc !== cc0) begin
      n_bad++; $display("FAIL imem_error: got stat=%b cc=%b want stat=10 cc=%b", m_stat, cc, cc0);
    end
    imem_error = 0; down_exc = 1;
    tick();
    n_cmp++;
    if (m_stat !== 2'b00 || cc !== cc0) begin
      n_bad++; $display("FAIL down_exc: got stat=%b cc=%b want stat=00 cc=%b", m_stat, cc, cc0);
    end
    down_exc = 0; ifun = 5;
    tick();
    n_cmp++;
    if (m_stat !== 2'b11 || cc !== cc0) begin
      n_bad++; $display("FAIL bad_ifun: got stat=%b cc=%b want stat=11 cc=%b", m_stat, cc, cc0);
    end
    icode = 0; ifun = 0;
    tick();
    n_cmp++;
    if (m_stat !== 2'b01 || m_icode !== 4'h0) begin
      n_bad++; $display("FAIL halt: got stat=%b ic=%h want stat=01 ic=0", m_stat, m_icode);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    logic [2:0] cc0;
    cc0 = e_cc;
    in_valid = 1; icode = 6; ifun = 0; valA = 1; valB = 2; dstE_in = 4'h5; flush = 1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || cc !== cc0 || m_dstE !== 4'hF || m_icode !== 4'h1) begin
      n_bad++; $display("FAIL flush: got ov=%b cc=%b dstE=%h ic=%h want ov=0 cc=%b dstE=f ic=1", out_valid, cc, m_dstE, m_icode, cc0);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      in_valid    = ($urandom_range(0, 9) < 8);
      out_ready   = ($urandom_range(0, 9) < 7);
      icode       = 4'($urandom_range(0, 11));
      ifun        = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(0, 15));
      valA        = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 4)) : {$urandom, $urandom};
      valB        = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 4)) : {$urandom, $urandom};
      valC        = {$urandom, $urandom};
      valP        = {$urandom, $urandom};
      dstE_in     = 4'($urandom_range(0, 15));
      dstM_in     = 4'($urandom_range(0, 15));
      stat_in     = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      instr_valid = ($urandom_range(0, 19) != 0);
      imem_error  = ($urandom_range(0, 19) == 0);
      down_exc    = ($urandom_range(0, 9) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      #1;
      n_cmp++;
      if (in_ready !== (!e_valid || out_ready)) begin
        n_bad++; $display("FAIL rand_in_ready: iter %0d got %b want %b", n, in_ready, !e_valid || out_ready);
      end
      tick();
      n_cmp++;
      if ({out_valid, m_icode, m_valE, m_valA, m_valP, m_dstE, m_dstM, m_cnd, m_stat, cc} !==
          {e_valid, e_icode, e_valE, e_valA, e_valP, e_dstE, e_dstM, e_cnd, e_stat, e_cc}) begin
        n_bad++;
        $display("FAIL rand_slot: iter %0d got ov=%b ic=%h E=%h A=%h P=%h dE=%h dM=%h c=%b s=%b cc=%b want ov=%b ic=%h E=%h A=%h P=%h dE=%h dM=%h c=%b s=%b cc=%b",
                 n, out_valid, m_icode, m_valE, m_valA, m_valP, m_dstE, m_dstM, m_cnd, m_stat, cc,
                 e_valid, e_icode, e_valE, e_valA, e_valP, e_dstE, e_dstM, e_cnd, e_stat, e_cc);
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_overflow();
    test_sub_zero();
    test_stack_backpressure();
    test_exceptions();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
